// File: rtl/tt_sweep_pkg.sv
// Shared types and helpers for the truth-table sweep controller.
// Gray-order stepping is selected by defining TT_SWEEP_GRAY_EN.
package tt_sweep_pkg;

   localparam int unsigned N_IN_DEF        = 3;
   localparam int unsigned HOLD_CYCLES_DEF = 10;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } sweep_state_e;

   function automatic logic [31:0] bin2gray(input logic [31:0] i_bin);
      return i_bin ^ (i_bin >> 1);
   endfunction

endpackage

// File: rtl/tt_hold_timer.sv
// Hold-window timer: counts 0..HOLD_CYCLES-1 while enabled, wraps to 0 after
// the terminal count, and is reloaded to 0 by i_clr.
module tt_hold_timer
   import tt_sweep_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF,
   localparam int unsigned CW = $clog2(HOLD_CYCLES + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc
);

   logic [CW-1:0] r_count;
   logic          w_tc;

   assign w_tc = (r_count == CW'(HOLD_CYCLES - 1));
   assign o_tc = w_tc;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_count <= '0;
      end else if (i_en) begin
         r_count <= w_tc ? '0 : r_count + 1'b1;
      end
   end

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Truth-table sweep controller: steps abc_o through every input code, samples f_i
// at the end of each hold window and builds the minterm vector. TT_SWEEP_GRAY_EN
// selects reflected Gray stepping order.
module tt_sweep_ctrl
   import tt_sweep_pkg::*;
#(
   parameter int unsigned N_IN        = N_IN_DEF,
   parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF,
   localparam int unsigned N_COMB = 2 ** N_IN
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [N_IN-1:0]   abc_o,
   input  logic              f_i,
   output logic              busy,
   output logic              done,
   output logic [N_COMB-1:0] minterms
);

   sweep_state_e r_state;
   sweep_state_e w_state_next;

   logic [N_IN-1:0]   r_idx;
   logic [N_IN-1:0]   r_abc;
   logic [N_COMB-1:0] r_minterms;
   logic [N_IN-1:0]   w_idx_next;
   logic [N_IN-1:0]   w_code_next;
   logic              w_launch;
   logic              w_run;
   logic              w_tc;
   logic              w_last;
   logic              w_step;

   assign w_launch   = (r_state == StIdle) && start;
   assign w_run      = (r_state == StRun);
   assign w_last     = &r_idx;
   assign w_step     = w_run && w_tc;
   assign w_idx_next = r_idx + 1'b1;

   always_comb begin
`ifdef TT_SWEEP_GRAY_EN
      w_code_next = N_IN'(bin2gray(32'(w_idx_next)));
`else
      w_code_next = w_idx_next;
`endif
   end

   tt_hold_timer #(
      .HOLD_CYCLES(HOLD_CYCLES)
   ) u_hold_timer (
      .clk  (clk),
      .rst  (rst),
      .i_clr(w_launch),
      .i_en (w_run),
      .o_tc (w_tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (start) w_state_next = StRun;
         StRun:   if (w_tc && w_last) w_state_next = StDone;
         StDone:  w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_comb begin
      busy = (r_state == StRun);
      done = (r_state == StDone);
   end

   // Code 0 is the first step in both binary and Gray order.
   always_ff @(posedge clk) begin
      if (rst || w_launch) begin
         r_idx      <= '0;
         r_abc      <= '0;
         r_minterms <= '0;
      end else if (w_step) begin
         r_minterms[r_abc] <= f_i;
         if (!w_last) begin
            r_idx <= w_idx_next;
            r_abc <= w_code_next;
         end
      end
   end

   assign abc_o    = r_abc;
   assign minterms = r_minterms;

endmodule
